// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, counter debounce, press/release
// edge pulses, long-press detect and optional auto-repeat, one independent slice per channel.
module button_conditioner #(
  parameter int N_CH          = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int REPEAT_EN     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int DB_W     = $clog2(DB_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam bit RPT_ON   = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    hold_state_t            state_q, state_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic s, rise, fall;

    // Debounce and edge detect; edges come from level_d so pulses align with the level flip.
    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in[gi]};
      s        = sync_q[SYNC_STAGES-1];
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      if (s == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d  = s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
      rise      = level_d & ~level_q;
      fall      = ~level_d & level_q;
      press_d   = rise;
      release_d = fall;
    end

    // A falling level overrides any long/repeat pulse due on the same edge.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      if (fall) begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_d    = HELD;
              hold_cnt_d = HOLD_W'(1);
            end else begin
              hold_cnt_d = '0;
            end
          end
          HELD: begin
            if (hold_cnt_q == HOLD_W'(LONG_CYCLES)) begin
              long_d     = 1'b1;
              state_d    = LONG;
              hold_cnt_d = HOLD_W'(1);
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
          LONG: begin
            if (RPT_ON && (hold_cnt_q == HOLD_W'(REPEAT_CYCLES))) begin
              repeat_d   = 1'b1;
              hold_cnt_d = HOLD_W'(1);
            end else if (hold_cnt_q != '1) begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
          default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q     <= '0;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        state_q    <= IDLE;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        sync_q     <= sync_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        state_q    <= state_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
      end
    end

    assign level[gi]         = level_q;
    assign press[gi]         = press_q;
    assign release_pulse[gi] = release_q;
    assign long_press[gi]    = long_q;
    assign repeat_pulse[gi]  = repeat_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected pulse events (cycle, kind) are queued per instance/channel
// as stimulus is driven and popped as pulses appear on the two DUTs (repeat on / off).
module tb_button_conditioner;

  localparam int N_CH   = 2;
  localparam int LAT    = 5;   // SYNC_STAGES + DB_CYCLES - 1
  localparam int LONG_C = 20;
  localparam int RPT_C  = 5;
  localparam int BIG    = 1 << 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_CH-1:0] btn_in = '1;
  logic [N_CH-1:0] level_a, press_a, rel_a, long_a, rpt_a;
  logic [N_CH-1:0] level_b, press_b, rel_b, long_b, rpt_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner #(
    .N_CH(N_CH), .SYNC_STAGES(2), .DB_CYCLES(4),
    .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(RPT_C), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level_a), .press(press_a),
    .release_pulse(rel_a), .long_press(long_a), .repeat_pulse(rpt_a)
  );

  button_conditioner #(
    .N_CH(N_CH), .SYNC_STAGES(2), .DB_CYCLES(4),
    .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(RPT_C), .REPEAT_EN(0)
  ) dut_norpt (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level_b), .press(press_b),
    .release_pulse(rel_b), .long_press(long_b), .repeat_pulse(rpt_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string kind_name(input int kd);
    case (kd)
      0: return "press";
      1: return "long_press";
      2: return "repeat";
      default: return "release";
    endcase
  endfunction

  function automatic bit pulse_bit(input int inst, input int ch, input int kd);
    logic [N_CH-1:0] v;
    case (kd)
      0: v = (inst != 0) ? press_b : press_a;
      1: v = (inst != 0) ? long_b : long_a;
      2: v = (inst != 0) ? rpt_b : rpt_a;
      default: v = (inst != 0) ? rel_b : rel_a;
    endcase
    return v[ch];
  endfunction

  function automatic int all_outs();
    return int'({level_a, press_a, rel_a, long_a, rpt_a, level_b, press_b, rel_b, long_b, rpt_b});
  endfunction

  // Button high on edges e..e+h-1; events at or after cut (a reset edge) are not expected.
  task automatic expect_hold(input int ch, input int e, input int h, input int cut);
    int t0, tf, tl;
    t0 = e + LAT;
    tf = e + h + LAT;
    tl = t0 + LONG_C;
    for (int inst = 0; inst < 2; inst++) begin
      int k;
      k = inst * 2 + ch;
      if (t0 < cut) exp_q[k].push_back(t0 * 4 + 0);
      if (tl < tf && tl < cut) exp_q[k].push_back(tl * 4 + 1);
      if (inst == 0) begin
        for (int t = tl + RPT_C; t < tf && t < cut; t += RPT_C) exp_q[k].push_back(t * 4 + 2);
      end
      if (tf < cut) exp_q[k].push_back(tf * 4 + 3);
    end
  endtask

  always @(negedge clk) begin
    for (int inst = 0; inst < 2; inst++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        for (int kd = 0; kd < 4; kd++) begin
          if (pulse_bit(inst, ch, kd)) begin
            int k, got;
            k = inst * 2 + ch;
            got = cyc * 4 + kd;
            $display("pulse: inst %0d ch %0d %s at cycle %0d", inst, ch, kind_name(kd), cyc);
            if (exp_q[k].size() == 0) check("unexpected_pulse", got, -1);
            else check(kind_name(kd), got, exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic run_pulses(input int h0, input int s1, input int h1, input int len);
    int base;
    @(negedge clk);
    base = cyc + 1;
    if (h0 > 0) expect_hold(0, base, h0, BIG);
    if (h1 > 0) expect_hold(1, base + s1, h1, BIG);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      btn_in[0] = (i < h0);
      btn_in[1] = (i >= s1) && (i < s1 + h1);
    end
  endtask

  initial begin
    int base, r;
    // Reset with buttons held, then release reset and watch the debounced rise.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", all_outs(), 0);
    end
    rst = 1'b0;
    base = cyc + 1;
    expect_hold(0, base, 10, BIG);
    expect_hold(1, base, 10, BIG);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("level0_after_reset", int'(level_a[0]), int'(cyc >= base + LAT));
    end
    btn_in = '0;
    repeat (15) @(negedge clk);

    // Short glitches never reach the debounced level.
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        btn_in[0] = (i < 3);
        check("glitch_level", int'(level_a[0] | level_b[0]), 0);
      end
    end
    btn_in = '0;
    repeat (10) @(negedge clk);
    check("glitch_level_end", int'(level_a[0] | level_b[0]), 0);

    run_pulses(40, 0, 0, 60);   // long press with repeats
    run_pulses(20, 0, 0, 40);   // level falls on the long_press edge
    run_pulses(40, 8, 6, 60);   // ch0 held while ch1 tapped

    // Reset while in LONG, button still held.
    @(negedge clk);
    base = cyc + 1;
    btn_in = 2'b01;
    r = base + LAT + LONG_C + 2;
    expect_hold(0, base, BIG, r);
    while (cyc < r - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_long_outputs", all_outs(), 0);
    expect_hold(0, r + 1, 30, BIG);
    while (cyc < r + 30) @(negedge clk);
    btn_in = '0;
    repeat (20) @(negedge clk);

    for (int k = 0; k < 4; k++) check("events_left", exp_q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
